// File: rtl/local_bus_arb_pkg.sv
// Shared types and constants for the local bus master arbiter.
package local_bus_arb_pkg;

   // Arbiter/sequencer state: arbitrate, drive command, wait for read data, complete
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RWAIT = 2'd2,
      ACK   = 2'd3
   } state_t;

   // Bus direction encoding on rw_direction / req_rw
   localparam logic LB_WRITE = 1'b1;
   localparam logic LB_READ  = 1'b0;

endpackage

// File: rtl/local_bus_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or above ptr, with wrap.
module local_bus_rr_arbiter
   import local_bus_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W:0] cand;

   // Scan offsets from far to near so the nearest requester above ptr wins
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
            cand = cand - (IDX_W + 1)'(NUM_REQ);
         end
         if (req[cand[IDX_W-1:0]]) begin
            grant_idx   = cand[IDX_W-1:0];
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/local_bus_master_arbiter.sv
// Shares one local bus master port between NUM_REQ requesters: round-robin
// arbitration, one command per grant, bounded wait for read data, and a
// one-cycle completion pulse back to the granted requester.
module local_bus_master_arbiter
   import local_bus_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         ack_rdata,
   output logic                      ack_err,
   output logic                      busy,
   output logic                      addr_en,
   output logic [ADDR_W-1:0]         addr,
   output logic                      rw_direction,
   output logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W-1:0]         rdata,
   input  logic                      rvalid
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   state_t state_reg, state_next;

   // Transaction latched at grant time
   logic [IDX_W-1:0]  win_idx_reg;
   logic              win_rw_reg;
   logic [ADDR_W-1:0] win_addr_reg;
   logic [IDX_W-1:0]  ptr_reg;
   logic [CNT_W-1:0]  cnt_reg;

   // Registered outputs and their next values
   logic [NUM_REQ-1:0] ack_reg, ack_next;
   logic [DATA_W-1:0]  ack_rdata_reg, ack_rdata_next;
   logic               ack_err_reg, ack_err_next;
   logic               busy_reg, busy_next;
   logic               addr_en_reg, addr_en_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic               rw_reg, rw_next;
   logic [DATA_W-1:0]  wdata_reg, wdata_next;

   logic [IDX_W-1:0]  grant_idx;
   logic              grant_valid;
   logic              timeout_hit;

   logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
   logic [DATA_W-1:0] wdata_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
   end

   local_bus_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req         (req),
      .ptr         (ptr_reg),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: requests only matter in IDLE; rvalid takes priority over the final count
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_valid) state_next = ISSUE;
         ISSUE:   state_next = (win_rw_reg == LB_WRITE) ? ACK : RWAIT;
         RWAIT:   if (rvalid || timeout_hit) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output values for the upcoming state; registered below so every output is a flop
   always_comb begin
      ack_next       = '0;
      ack_rdata_next = '0;
      ack_err_next   = 1'b0;
      addr_en_next   = 1'b0;
      addr_next      = '0;
      rw_next        = 1'b0;
      wdata_next     = '0;
      busy_next      = (state_next != IDLE);
      case (state_next)
         ISSUE: begin
            // ISSUE is only entered from IDLE, so the arbiter output is the winner
            addr_en_next = 1'b1;
            addr_next    = addr_arr[grant_idx];
            rw_next      = req_rw[grant_idx];
            wdata_next   = wdata_arr[grant_idx];
         end
         RWAIT: begin
            addr_next = win_addr_reg;
            rw_next   = win_rw_reg;
         end
         ACK: begin
            ack_next[win_idx_reg] = 1'b1;
            if (state_reg == RWAIT) begin
               ack_rdata_next = rvalid ? rdata : '0;
               ack_err_next   = ~rvalid;
            end
         end
         default: begin
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_reg       <= '0;
         ack_rdata_reg <= '0;
         ack_err_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         addr_en_reg   <= 1'b0;
         addr_reg      <= '0;
         rw_reg        <= 1'b0;
         wdata_reg     <= '0;
      end else begin
         ack_reg       <= ack_next;
         ack_rdata_reg <= ack_rdata_next;
         ack_err_reg   <= ack_err_next;
         busy_reg      <= busy_next;
         addr_en_reg   <= addr_en_next;
         addr_reg      <= addr_next;
         rw_reg        <= rw_next;
         wdata_reg     <= wdata_next;
      end
   end

   // Latch the winner and advance the rotation; run the read-wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_idx_reg  <= '0;
         win_rw_reg   <= 1'b0;
         win_addr_reg <= '0;
         ptr_reg      <= '0;
         cnt_reg      <= '0;
      end else begin
         if (state_reg == IDLE && grant_valid) begin
            win_idx_reg  <= grant_idx;
            win_rw_reg   <= req_rw[grant_idx];
            win_addr_reg <= addr_arr[grant_idx];
            ptr_reg      <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
         end
         if (state_reg == ISSUE) begin
            cnt_reg <= '0;
         end else if (state_reg == RWAIT) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign ack          = ack_reg;
   assign ack_rdata    = ack_rdata_reg;
   assign ack_err      = ack_err_reg;
   assign busy         = busy_reg;
   assign addr_en      = addr_en_reg;
   assign addr         = addr_reg;
   assign rw_direction = rw_reg;
   assign wdata        = wdata_reg;

endmodule

// File: tb/tb_local_bus_master_arbiter.sv
// Bench for local_bus_master_arbiter: transaction-level model predicts every bus
// command and every completion; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_local_bus_master_arbiter;
   import local_bus_arb_pkg::*;

   localparam int NR = 3;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR-1:0]     req_rw = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     ack;
   logic [DW-1:0]     ack_rdata;
   logic              ack_err;
   logic              busy;
   logic              addr_en;
   logic [AW-1:0]     addr;
   logic              rw_direction;
   logic [DW-1:0]     wdata;
   logic [DW-1:0]     rdata = '0;
   logic              rvalid = 1'b0;

   always #5 clk = ~clk;

   local_bus_master_arbiter #(
      .NUM_REQ (NR), .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TO)
   ) dut (
      .clk (clk), .reset (rst), .req (req), .req_rw (req_rw),
      .req_addr (req_addr), .req_wdata (req_wdata), .ack (ack),
      .ack_rdata (ack_rdata), .ack_err (ack_err), .busy (busy),
      .addr_en (addr_en), .addr (addr), .rw_direction (rw_direction),
      .wdata (wdata), .rdata (rdata), .rvalid (rvalid)
   );

   typedef struct { int cyc; logic [AW-1:0] addr; logic rw; logic [DW-1:0] wdata; } bus_exp_t;
   typedef struct { int cyc; int idx; logic [DW-1:0] rdata; logic err; } ack_exp_t;

   bus_exp_t bus_q[$];
   ack_exp_t ack_q[$];
   int       ack_log[$];

   int errors = 0;
   int checks = 0;

   // Requester-side view
   bit            pend    [NR];
   bit            grnt    [NR];
   bit            dropped [NR];
   logic          p_rw    [NR];
   logic [AW-1:0] p_addr  [NR];
   logic [DW-1:0] p_wdata [NR];
   int            last_ack[NR];

   // Arbiter model
   int cyc = 0, idle_at = 0, ptr_m = 0, last_grant = 0;
   int busy_lo = -1, busy_hi = -1, rw_lo = -1, rw_hi = -1;
   int rv_cyc = -1, stray_at = -1, force_delay = -1;
   bit force_rd = 0;
   logic [DW-1:0] force_rd_val = '0;
   logic [AW-1:0] rw_addr = '0;
   logic [DW-1:0] rv_data = '0;
   bit rand_en = 0;

   // Observed completion
   int obs_ack_cyc = 0;
   logic [DW-1:0] obs_rdata = '0;
   logic obs_err = 1'b0;
   logic prev_addr_en = 1'b0;
   bus_exp_t mon_be;
   ack_exp_t mon_ae;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic post(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1; grnt[i] = 0; dropped[i] = 0;
      p_rw[i] = rw; p_addr[i] = a; p_wdata[i] = d;
   endtask

   function automatic bit any_pend();
      bit r = 0;
      for (int i = 0; i < NR; i++) if (pend[i]) r = 1;
      return r;
   endfunction

   // One clock cycle: retire, new random requests, drive, then model arbitration
   task automatic step();
      int w, j, d, ack_c;
      logic [DW-1:0] r;
      logic e;
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NR; i++)
         if (pend[i] && grnt[i] && cyc > last_ack[i]) begin
            pend[i] = 0; grnt[i] = 0; dropped[i] = 0;
         end
      if (rand_en)
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && cyc > last_ack[i] + 1 && $urandom_range(0, 3) == 0)
               post(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            else if (grnt[i] && !dropped[i] && $urandom_range(0, 2) == 0)
               dropped[i] = 1;
         end
      for (int i = 0; i < NR; i++) begin
         req[i] = pend[i] && !dropped[i];
         req_rw[i] = p_rw[i];
         req_addr[i*AW +: AW] = p_addr[i];
         req_wdata[i*DW +: DW] = p_wdata[i];
      end
      rvalid = 1'b0;
      rdata = DW'($urandom);
      if (cyc == rv_cyc) begin
         rvalid = 1'b1; rdata = rv_data;
      end else if (cyc == stray_at) begin
         rvalid = 1'b1;
      end else if (rand_en && !(cyc >= rw_lo && cyc <= rw_hi) && $urandom_range(0, 7) == 0) begin
         rvalid = 1'b1;
      end
      if (!rst && cyc >= idle_at) begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            j = (ptr_m + k) % NR;
            if (w < 0 && pend[j] && !dropped[j]) w = j;
         end
         if (w >= 0) begin
            grnt[w] = 1;
            ptr_m = (w + 1) % NR;
            bus_q.push_back('{cyc + 1, p_addr[w], p_rw[w], p_wdata[w]});
            r = '0; e = 1'b0;
            if (p_rw[w] == LB_WRITE) begin
               ack_c = cyc + 2;
            end else begin
               d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, TO + 3));
               force_delay = -1;
               rw_lo = cyc + 2; rw_addr = p_addr[w];
               if (d < TO) begin
                  rv_cyc = cyc + 2 + d;
                  rv_data = force_rd ? force_rd_val : DW'($urandom);
                  force_rd = 0;
                  ack_c = rv_cyc + 1; r = rv_data;
               end else begin
                  ack_c = cyc + 2 + TO; e = 1'b1;
               end
               rw_hi = ack_c - 1;
            end
            ack_q.push_back('{ack_c, w, r, e});
            last_ack[w] = ack_c; idle_at = ack_c + 1;
            busy_lo = cyc + 1; busy_hi = ack_c; last_grant = cyc;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((any_pend() || cyc < idle_at) && n < 500) begin step(); n++; end
      if (n >= 500) chk("drain_timeout", 1, 0);
   endtask

   task automatic wait_free(input int i);
      int n = 0;
      while ((pend[i] || cyc <= last_ack[i]) && n < 100) begin step(); n++; end
      if (n >= 100) chk("wait_free_timeout", 1, 0);
   endtask

   task automatic model_reset();
      bus_q.delete(); ack_q.delete();
      for (int i = 0; i < NR; i++) begin pend[i] = 0; grnt[i] = 0; dropped[i] = 0; last_ack[i] = -10; end
      ptr_m = 0; idle_at = 1 << 30;
      busy_lo = -1; busy_hi = -1; rw_lo = -1; rw_hi = -1;
      rv_cyc = -1; stray_at = -1; force_delay = -1; force_rd = 0;
   endtask

   // Monitor: pop the expectation whenever the DUT presents a command or completion
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
            chk("bus_cmd_missing", 0, 1);
            void'(bus_q.pop_front());
         end
         if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            chk("ack_missing", 0, 1);
            void'(ack_q.pop_front());
         end
         if (addr_en) begin
            chk("addr_en_back_to_back", 32'(prev_addr_en), 0);
            if (bus_q.size() == 0) chk("bus_cmd_unexpected", 1, 0);
            else begin
               mon_be = bus_q.pop_front();
               chk("bus_cmd_cycle", cyc, mon_be.cyc);
               chk("bus_addr", 32'(addr), 32'(mon_be.addr));
               chk("bus_rw", 32'(rw_direction), 32'(mon_be.rw));
               chk("bus_wdata", 32'(wdata), 32'(mon_be.wdata));
            end
         end
         if (ack != '0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", 32'(ack), 0);
            else begin
               mon_ae = ack_q.pop_front();
               chk("ack_cycle", cyc, mon_ae.cyc);
               chk("ack_onehot", 32'(ack), 32'(1) << mon_ae.idx);
               chk("ack_rdata", 32'(ack_rdata), 32'(mon_ae.rdata));
               chk("ack_err", 32'(ack_err), 32'(mon_ae.err));
            end
            for (int k = 0; k < NR; k++) if (ack[k]) ack_log.push_back(k);
            obs_ack_cyc = cyc; obs_rdata = ack_rdata; obs_err = ack_err;
            $display("txn cyc=%0d ack=%b rdata=0x%04h err=%0d", cyc, ack, ack_rdata, ack_err);
         end else begin
            chk("ack_side_idle_zero", {15'd0, ack_err, ack_rdata}, 0);
         end
         chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
         if (cyc >= rw_lo && cyc <= rw_hi)
            chk("rwait_bus_hold", {addr_en, rw_direction, addr, wdata[13:0]} ,
                {1'b0, 1'b0, rw_addr, 14'd0});
      end
      prev_addr_en = addr_en;
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         pend[i] = 0; grnt[i] = 0; dropped[i] = 0; last_ack[i] = -10;
         p_rw[i] = 0; p_addr[i] = '0; p_wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {addr_en, busy, rw_direction, ack_err, ack, addr, wdata[7:0]} , 0);
      chk("reset_state_data", {ack_rdata, wdata}, 0);
      rst = 1'b0; cyc = 0; idle_at = 0;

      // Single write
      post(0, LB_WRITE, 16'h0010, 16'hA5A5);
      drain();
      chk("write_latency", obs_ack_cyc - last_grant, 2);
      chk("write_err", 32'(obs_err), 0);

      // Single read: rvalid three cycles after addr_en
      force_delay = 2; force_rd = 1; force_rd_val = 16'h1234;
      post(1, LB_READ, 16'h0020, 16'h0000);
      drain();
      chk("read_latency", obs_ack_cyc - last_grant, 5);
      chk("read_rdata", 32'(obs_rdata), 32'h1234);

      // Contention between requesters 0 and 1, four writes
      ack_log.delete();
      post(0, LB_WRITE, 16'h0100, 16'h1111);
      post(1, LB_WRITE, 16'h0200, 16'h2222);
      wait_free(0); post(0, LB_WRITE, 16'h0101, 16'h3333);
      wait_free(1); post(1, LB_WRITE, 16'h0201, 16'h4444);
      drain();
      chk("contention_count", ack_log.size(), 4);
      if (ack_log.size() == 4)
         chk("contention_order", {ack_log[0][7:0], ack_log[1][7:0], ack_log[2][7:0], ack_log[3][7:0]},
             32'h00010001);

      // Read timeout with a stray rvalid the cycle after ack
      force_delay = TO + 5;
      post(0, LB_READ, 16'h0030, 16'h0000);
      step();
      stray_at = last_ack[0] + 1;
      drain();
      chk("timeout_latency", obs_ack_cyc - last_grant, TO + 2);
      chk("timeout_err", 32'(obs_err), 1);
      chk("timeout_rdata", 32'(obs_rdata), 0);

      // Reset in RWAIT: everything drops at once, no ack, rotation restarts at 0
      force_delay = TO + 5;
      post(0, LB_READ, 16'h0040, 16'h0000);
      step();
      repeat (3) step();
      chk("busy_before_reset", 32'(busy), 1);
      #1 rst = 1'b1;
      #1;
      chk("reset_abort", {addr_en, busy, ack}, 0);
      model_reset();
      step(); step();
      rst = 1'b0; idle_at = cyc;
      ack_log.delete();
      post(0, LB_WRITE, 16'h0050, 16'h5555);
      post(1, LB_WRITE, 16'h0060, 16'h6666);
      drain();
      chk("post_reset_count", ack_log.size(), 2);
      if (ack_log.size() == 2)
         chk("post_reset_order", {ack_log[0][15:0], ack_log[1][15:0]}, 32'h00000001);

      // Randomized traffic
      rand_en = 1;
      repeat (1500) step();
      rand_en = 0;
      drain();
      repeat (2) step();
      chk("leftover_expectations", bus_q.size() + ack_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
